mem_req_arbiter: RTL and testbench

//  Two-port request arbiter sitting directly upstream of the PSRAM memory controller.

---
 rtl/mem_req_arbiter_if.sv | 34 +++
 rtl/mem_req_arbiter.sv | 102 ++++++++++
 tb/tb_mem_req_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Request/ack and PSRAM-controller handshake bundle for mem_req_arbiter.
// master = arbiter view, slave = requesters plus controller view.
interface mem_req_arbiter_if;
  logic        i_reqA, i_reqB;
  logic        i_weA, i_weB;
  logic [23:0] i_addrA, i_addrB;
  logic        i_bankA, i_bankB;
  logic [7:0]  i_wdataA, i_wdataB;
  logic        o_ackA, o_ackB;
  logic [7:0]  o_rdata;
  logic        o_err;
  logic        o_mem_cs;
  logic        o_mem_write;
  logic [23:0] o_mem_addr;
  logic        o_mem_bank;
  logic [7:0]  o_mem_wdata;
  logic        i_mem_busy;
  logic        i_mem_ready;
  logic [7:0]  i_mem_rdata;

  modport master (
    input  i_reqA, i_reqB, i_weA, i_weB, i_addrA, i_addrB, i_bankA, i_bankB,
           i_wdataA, i_wdataB, i_mem_busy, i_mem_ready, i_mem_rdata,
    output o_ackA, o_ackB, o_rdata, o_err, o_mem_cs, o_mem_write, o_mem_addr,
           o_mem_bank, o_mem_wdata
  );

  modport slave (
    output i_reqA, i_reqB, i_weA, i_weB, i_addrA, i_addrB, i_bankA, i_bankB,
           i_wdataA, i_wdataB, i_mem_busy, i_mem_ready, i_mem_rdata,
    input  o_ackA, o_ackB, o_rdata, o_err, o_mem_cs, o_mem_write, o_mem_addr,
           o_mem_bank, o_mem_wdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-port byte-request arbiter feeding the PSRAM controller; ARB_ROUND_ROBIN_EN selects alternating tie grant.
// Latency req->ack 4 cycles + controller time; requesters hold req until their ack, one transfer in flight.
module mem_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter bit PRIO_B         = 1'b1
) (
  input  logic i_clkRAM,
  input  logic reset,
  mem_req_arbiter_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARM, ACCEPT, DONE_WAIT, ACK} state_t;

  state_t        state;
  logic          grant_b;
  logic [CW-1:0] tmo_cnt;
  logic          pick_b;
  logic          tmo_hit;
  logic          xfer_done;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_prefer_b;
  assign pick_b = bus.i_reqB && (!bus.i_reqA || rr_prefer_b);
`else
  assign pick_b = bus.i_reqB && (!bus.i_reqA || PRIO_B);
`endif

  assign tmo_hit   = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign xfer_done = bus.o_mem_write ? !bus.i_mem_busy
                                     : (bus.i_mem_ready && !bus.i_mem_busy);

  always_ff @(posedge i_clkRAM or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      grant_b         <= 1'b0;
      tmo_cnt         <= '0;
      bus.o_ackA      <= 1'b0;
      bus.o_ackB      <= 1'b0;
      bus.o_rdata     <= 8'h00;
      bus.o_err       <= 1'b0;
      bus.o_mem_cs    <= 1'b1;
      bus.o_mem_write <= 1'b0;
      bus.o_mem_addr  <= 24'h000000;
      bus.o_mem_bank  <= 1'b0;
      bus.o_mem_wdata <= 8'h00;
`ifdef ARB_ROUND_ROBIN_EN
      rr_prefer_b     <= 1'b1;
`endif
    end else begin
      bus.o_ackA <= 1'b0;
      bus.o_ackB <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (bus.i_reqA || bus.i_reqB) begin
            grant_b         <= pick_b;
            bus.o_mem_write <= pick_b ? bus.i_weB    : bus.i_weA;
            bus.o_mem_addr  <= pick_b ? bus.i_addrB  : bus.i_addrA;
            bus.o_mem_bank  <= pick_b ? bus.i_bankB  : bus.i_bankA;
            bus.o_mem_wdata <= pick_b ? bus.i_wdataB : bus.i_wdataA;
`ifdef ARB_ROUND_ROBIN_EN
            rr_prefer_b     <= !pick_b;
`endif
            state           <= ARM;
          end
        end
        ARM, ACCEPT, DONE_WAIT: begin
          if (tmo_hit) begin
            // Abort still acks so a stuck controller never hangs a requester.
            bus.o_err    <= 1'b1;
            bus.o_mem_cs <= 1'b1;
            bus.o_rdata  <= 8'hFF;
            bus.o_ackA   <= !grant_b;
            bus.o_ackB   <= grant_b;
            state        <= ACK;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (state == ARM) begin
              if (!bus.i_mem_busy) begin
                bus.o_mem_cs <= 1'b0;
                state        <= ACCEPT;
              end
            end else if (state == ACCEPT) begin
              if (bus.i_mem_busy) begin
                bus.o_mem_cs <= 1'b1;
                state        <= DONE_WAIT;
              end
            end else if (xfer_done) begin
              if (!bus.o_mem_write) bus.o_rdata <= bus.i_mem_rdata;
              bus.o_ackA <= !grant_b;
              bus.o_ackB <= grant_b;
              state      <= ACK;
            end
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboarded bench for mem_req_arbiter with a behavioural PSRAM-controller model.
// Build with or without ARB_ROUND_ROBIN_EN; the expected grant order follows the macro.
module tb_mem_req_arbiter;
  localparam int TMO = 16;

  logic i_clkRAM = 1'b0;
  logic reset;

  mem_req_arbiter_if bus();

  mem_req_arbiter #(.TIMEOUT_CYCLES(TMO), .PRIO_B(1'b1)) dut (
    .i_clkRAM(i_clkRAM),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 i_clkRAM = ~i_clkRAM;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port_b;
    logic        we;
    logic [23:0] addr;
    logic        bank;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        err;
    int          pulses;
  } exp_t;

  exp_t sb[$];

  // Controller model: edge-detects cs low, busy for mdl_lat+1 cycles, read data with ready.
  logic       mdl_stuck = 1'b0;
  int         mdl_lat = 2;
  logic [7:0] mdl_rdata = 8'h00;
  int         mdl_cnt;
  logic       mdl_we;
  logic       mdl_prev_cs;

  always @(posedge i_clkRAM or posedge reset) begin
    if (reset) begin
      bus.i_mem_busy  <= 1'b0;
      bus.i_mem_ready <= 1'b0;
      bus.i_mem_rdata <= 8'h00;
      mdl_cnt         <= 0;
      mdl_we          <= 1'b0;
      mdl_prev_cs     <= 1'b1;
    end else begin
      mdl_prev_cs     <= bus.o_mem_cs;
      bus.i_mem_ready <= 1'b0;
      if (mdl_stuck) begin
        bus.i_mem_busy <= 1'b1;
        mdl_cnt        <= 0;
        mdl_we         <= 1'b1;
      end else if (bus.i_mem_busy) begin
        if (mdl_cnt == 0) begin
          bus.i_mem_busy  <= 1'b0;
          bus.i_mem_ready <= !mdl_we;
          bus.i_mem_rdata <= mdl_rdata;
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end else if (!bus.o_mem_cs && mdl_prev_cs) begin
        bus.i_mem_busy <= 1'b1;
        mdl_cnt        <= mdl_lat;
        mdl_we         <= bus.o_mem_write;
      end
    end
  end

  // Monitor: counts cs strobes, captures the bus at the strobe, checks every ack against the scoreboard.
  int          cs_falls = 0;
  logic        mon_prev_cs = 1'b1;
  logic [23:0] cap_addr;
  logic        cap_bank, cap_write;
  logic [7:0]  cap_wdata;
  exp_t        mon_e;

  always @(negedge i_clkRAM) begin
    if (reset) begin
      cs_falls    = 0;
      mon_prev_cs = 1'b1;
    end else begin
      if (!bus.o_mem_cs && mon_prev_cs) begin
        cs_falls++;
        cap_addr  = bus.o_mem_addr;
        cap_bank  = bus.o_mem_bank;
        cap_write = bus.o_mem_write;
        cap_wdata = bus.o_mem_wdata;
      end
      mon_prev_cs = bus.o_mem_cs;
      if (bus.o_ackA || bus.o_ackB) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: ackA=%b ackB=%b with nothing outstanding", bus.o_ackA, bus.o_ackB);
        end else begin
          mon_e = sb.pop_front();
          chk("ackB", bus.o_ackB, mon_e.port_b);
          chk("ackA", bus.o_ackA, !mon_e.port_b);
          chk("rdata", bus.o_rdata, mon_e.rdata);
          chk("err", bus.o_err, mon_e.err);
          chk("mem_addr", bus.o_mem_addr, mon_e.addr);
          chk("mem_bank", bus.o_mem_bank, mon_e.bank);
          chk("mem_write", bus.o_mem_write, mon_e.we);
          chk("mem_wdata", bus.o_mem_wdata, mon_e.wdata);
          chk("cs_pulses", cs_falls, mon_e.pulses);
          if (cs_falls > 0) begin
            chk("cs_addr", cap_addr, mon_e.addr);
            chk("cs_bank", cap_bank, mon_e.bank);
            chk("cs_write", cap_write, mon_e.we);
            chk("cs_wdata", cap_wdata, mon_e.wdata);
          end
        end
        cs_falls = 0;
      end
    end
  end

  function automatic exp_t mk(input logic b, input logic we, input logic [23:0] addr,
                              input logic bank, input logic [7:0] wdata,
                              input logic [7:0] rdata, input logic err, input int pulses);
    exp_t e;
    e.port_b = b;  e.we = we;  e.addr = addr;  e.bank = bank;
    e.wdata = wdata;  e.rdata = rdata;  e.err = err;  e.pulses = pulses;
    return e;
  endfunction

  task automatic set_port(input logic b, input logic we, input logic [23:0] addr,
                          input logic bank, input logic [7:0] wdata);
    if (b) begin
      bus.i_weB = we;  bus.i_addrB = addr;  bus.i_bankB = bank;  bus.i_wdataB = wdata;
    end else begin
      bus.i_weA = we;  bus.i_addrA = addr;  bus.i_bankA = bank;  bus.i_wdataA = wdata;
    end
  endtask

  task automatic wait_any(input int limit, output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int i = 0; i < limit && who < 0; i++) begin
      @(negedge i_clkRAM);
      cyc = i + 1;
      if (bus.o_ackB) who = 1;
      else if (bus.o_ackA) who = 0;
    end
  endtask

  task automatic wait_or_fail(input string name, output int who, output int cyc);
    wait_any(100, who, cyc);
    if (who < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no ack within 100 cycles, required one", name);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clkRAM);
    reset = 1'b1;
    repeat (2) @(negedge i_clkRAM);
    reset = 1'b0;
    @(negedge i_clkRAM);
  endtask

  typedef struct {
    logic        b;
    logic        we;
    logic [23:0] addr;
    logic        bank;
    logic [7:0]  wdata;
    logic [7:0]  mrd;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[6];
  int   who, cyc;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 24'h000123, 1'b0, 8'h00, 8'h5A, 8'h5A};
    vecs[1] = '{1'b1, 1'b1, 24'hFFFFFF, 1'b1, 8'hC3, 8'h99, 8'h5A};
    vecs[2] = '{1'b0, 1'b1, 24'h800000, 1'b1, 8'h3C, 8'h99, 8'h5A};
    vecs[3] = '{1'b1, 1'b0, 24'h00FF00, 1'b0, 8'h11, 8'hA7, 8'hA7};
    vecs[4] = '{1'b0, 1'b0, 24'hFFFFFF, 1'b1, 8'h22, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 24'h000000, 1'b1, 8'h33, 8'h81, 8'h81};

    reset = 1'b1;
    bus.i_reqA = 1'b0;  bus.i_reqB = 1'b0;
    set_port(1'b0, 1'b0, 24'h0, 1'b0, 8'h0);
    set_port(1'b1, 1'b0, 24'h0, 1'b0, 8'h0);
    repeat (3) @(negedge i_clkRAM);
    chk("rst_cs", bus.o_mem_cs, 1'b1);
    chk("rst_ackA", bus.o_ackA, 1'b0);
    chk("rst_ackB", bus.o_ackB, 1'b0);
    chk("rst_rdata", bus.o_rdata, 8'h00);
    chk("rst_err", bus.o_err, 1'b0);
    chk("rst_addr", bus.o_mem_addr, 24'h0);
    chk("rst_write", bus.o_mem_write, 1'b0);
    chk("rst_bank", bus.o_mem_bank, 1'b0);
    chk("rst_wdata", bus.o_mem_wdata, 8'h00);
    reset = 1'b0;
    @(negedge i_clkRAM);

    // Single transfers from the table, one port at a time.
    for (int i = 0; i < 6; i++) begin
      mdl_rdata = vecs[i].mrd;
      set_port(vecs[i].b, vecs[i].we, vecs[i].addr, vecs[i].bank, vecs[i].wdata);
      sb.push_back(mk(vecs[i].b, vecs[i].we, vecs[i].addr, vecs[i].bank,
                      vecs[i].wdata, vecs[i].exp_rd, 1'b0, 1));
      if (vecs[i].b) bus.i_reqB = 1'b1; else bus.i_reqA = 1'b1;
      wait_or_fail("vec_ack", who, cyc);
      bus.i_reqA = 1'b0;
      bus.i_reqB = 1'b0;
      @(negedge i_clkRAM);
    end

    // Reset while the controller is still busy: transfer dropped, bus cleared at once.
    mdl_lat = 8;
    set_port(1'b0, 1'b0, 24'h0ABCDE, 1'b1, 8'h00);
    bus.i_reqA = 1'b1;
    for (int i = 0; i < 20 && bus.o_mem_cs; i++) @(negedge i_clkRAM);
    for (int i = 0; i < 20 && !bus.o_mem_cs; i++) @(negedge i_clkRAM);
    @(negedge i_clkRAM);
    reset = 1'b1;
    #1;
    chk("midrst_cs", bus.o_mem_cs, 1'b1);
    chk("midrst_addr", bus.o_mem_addr, 24'h0);
    chk("midrst_ackA", bus.o_ackA, 1'b0);
    bus.i_reqA = 1'b0;
    repeat (2) @(negedge i_clkRAM);
    reset = 1'b0;
    wait_any(12, who, cyc);
    chk("midrst_no_ack", who, -1);
    mdl_lat = 2;
    mdl_rdata = 8'h4E;
    sb.push_back(mk(1'b0, 1'b0, 24'h0ABCDE, 1'b1, 8'h00, 8'h4E, 1'b0, 1));
    bus.i_reqA = 1'b1;
    wait_or_fail("post_rst_ack", who, cyc);
    bus.i_reqA = 1'b0;

    // Simultaneous requests from reset: B first (priority or pointer), then A.
    do_reset();
    mdl_rdata = 8'h6D;
    set_port(1'b1, 1'b1, 24'h001000, 1'b0, 8'hE1);
    set_port(1'b0, 1'b0, 24'h002000, 1'b1, 8'h00);
    sb.push_back(mk(1'b1, 1'b1, 24'h001000, 1'b0, 8'hE1, 8'h00, 1'b0, 1));
    sb.push_back(mk(1'b0, 1'b0, 24'h002000, 1'b1, 8'h00, 8'h6D, 1'b0, 1));
    bus.i_reqA = 1'b1;
    bus.i_reqB = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_or_fail("tie_ack", who, cyc);
      if (who == 1) bus.i_reqB = 1'b0;
      if (who == 0) bus.i_reqA = 1'b0;
    end
    bus.i_reqA = 1'b0;
    bus.i_reqB = 1'b0;

    // Both held for four transfers.
    do_reset();
    mdl_rdata = 8'h77;
    set_port(1'b0, 1'b0, 24'h00A000, 1'b0, 8'h00);
    set_port(1'b1, 1'b0, 24'h00B000, 1'b1, 8'h00);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (k % 2 == 0) sb.push_back(mk(1'b1, 1'b0, 24'h00B000, 1'b1, 8'h00, 8'h77, 1'b0, 1));
      else            sb.push_back(mk(1'b0, 1'b0, 24'h00A000, 1'b0, 8'h00, 8'h77, 1'b0, 1));
`else
      sb.push_back(mk(1'b1, 1'b0, 24'h00B000, 1'b1, 8'h00, 8'h77, 1'b0, 1));
`endif
    end
    bus.i_reqA = 1'b1;
    bus.i_reqB = 1'b1;
    for (int k = 0; k < 4; k++) wait_or_fail("held_ack", who, cyc);
    bus.i_reqA = 1'b0;
    bus.i_reqB = 1'b0;
    @(negedge i_clkRAM);

    // Controller stuck busy: ack at timeout with FF and sticky error.
    mdl_stuck = 1'b1;
    repeat (2) @(negedge i_clkRAM);
    set_port(1'b0, 1'b0, 24'h123456, 1'b0, 8'h00);
    sb.push_back(mk(1'b0, 1'b0, 24'h123456, 1'b0, 8'h00, 8'hFF, 1'b1, 0));
    bus.i_reqA = 1'b1;
    wait_or_fail("tmo_ack", who, cyc);
    bus.i_reqA = 1'b0;
    chk("tmo_lat_min", (cyc >= TMO), 1'b1);
    chk("tmo_lat_max", (cyc <= TMO + 4), 1'b1);
    mdl_stuck = 1'b0;
    repeat (3) @(negedge i_clkRAM);
    chk("err_sticky", bus.o_err, 1'b1);
    mdl_rdata = 8'h12;
    set_port(1'b1, 1'b0, 24'h000321, 1'b1, 8'h00);
    sb.push_back(mk(1'b1, 1'b0, 24'h000321, 1'b1, 8'h00, 8'h12, 1'b1, 1));
    bus.i_reqB = 1'b1;
    wait_or_fail("after_tmo_ack", who, cyc);
    bus.i_reqB = 1'b0;
    repeat (4) @(negedge i_clkRAM);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, required to finish earlier");
    $fatal(1, "watchdog expired");
  end
endmodule
